// File: rtl/sram_d_arbiter.sv
// Two-master round-robin OBI arbiter in front of the SRAM data port.
// An in-order ID FIFO routes each response back to its issuing master.
module sram_d_arbiter #(
   parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000,
   parameter int unsigned MAX_OUTST      = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        m0_req_i,
   output logic        m0_gnt_o,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   output logic        m0_err_o,
   input  logic        m1_req_i,
   output logic        m1_gnt_o,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   output logic        m1_err_o,
   output logic        sram_d_req_o,
   input  logic        sram_d_gnt_i,
   output logic [31:0] sram_d_addr_o,
   output logic        sram_d_we_o,
   output logic [3:0]  sram_d_be_o,
   output logic [31:0] sram_d_wdata_o,
   input  logic        sram_d_rvalid_i,
   input  logic [31:0] sram_d_rdata_i,
   output logic        protocol_err_o
);

   localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTST);

   logic [MAX_OUTST-1:0] fifo_id_q, fifo_id_d;
   logic [MAX_OUTST-1:0] fifo_err_q, fifo_err_d;
   logic [PtrW-1:0]      wptr_q, wptr_d;
   logic [PtrW-1:0]      rptr_q, rptr_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 prio_q, prio_d;
   logic                 perr_q, perr_d;

   logic        fifo_empty, fifo_full;
   logic        head_id, head_err;
   logic        pop, push, accept_ok;
   logic        sel_m1, sel_req, in_range, grant;
   logic [31:0] sel_addr, sel_wdata, rsp_data;
   logic        sel_we;
   logic [3:0]  sel_be;

   always_comb begin
      fifo_empty = (cnt_q == '0);
      fifo_full  = (cnt_q == CntFull);
      head_id    = fifo_id_q[rptr_q];
      head_err   = fifo_err_q[rptr_q];
      // Error entries retire on their own; forwarded ones wait for the SRAM beat.
      pop        = !fifo_empty && (head_err || sram_d_rvalid_i);
      accept_ok  = !fifo_full || pop;

      sel_req   = m0_req_i | m1_req_i;
      sel_m1    = m1_req_i && (!m0_req_i || prio_q);
      sel_addr  = sel_m1 ? m1_addr_i  : m0_addr_i;
      sel_we    = sel_m1 ? m1_we_i    : m0_we_i;
      sel_be    = sel_m1 ? m1_be_i    : m0_be_i;
      sel_wdata = sel_m1 ? m1_wdata_i : m0_wdata_i;
      in_range  = (sel_addr >= SRAM_BASE_ADDR) && (sel_addr < SRAM_END_ADDR);

      sram_d_req_o   = sel_req && in_range && accept_ok;
      sram_d_addr_o  = sram_d_req_o ? sel_addr  : '0;
      sram_d_we_o    = sram_d_req_o ? sel_we    : 1'b0;
      sram_d_be_o    = sram_d_req_o ? sel_be    : '0;
      sram_d_wdata_o = sram_d_req_o ? sel_wdata : '0;

      grant    = in_range ? (sram_d_gnt_i && sram_d_req_o) : (sel_req && accept_ok);
      push     = grant;
      m0_gnt_o = grant && !sel_m1;
      m1_gnt_o = grant && sel_m1;

      rsp_data    = head_err ? '0 : sram_d_rdata_i;
      m0_rvalid_o = pop && !head_id;
      m1_rvalid_o = pop && head_id;
      m0_rdata_o  = m0_rvalid_o ? rsp_data : '0;
      m1_rdata_o  = m1_rvalid_o ? rsp_data : '0;
      m0_err_o    = m0_rvalid_o && head_err;
      m1_err_o    = m1_rvalid_o && head_err;
      protocol_err_o = perr_q;
   end

   always_comb begin
      fifo_id_d  = fifo_id_q;
      fifo_err_d = fifo_err_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      if (push) begin
         fifo_id_d[wptr_q]  = sel_m1;
         fifo_err_d[wptr_q] = !in_range;
         wptr_d             = wptr_q + PtrW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PtrW'(1);
      end
      cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
      prio_d = push ? !sel_m1 : prio_q;
      // A beat with nothing forwarded at the head is dropped and flagged.
      perr_d = perr_q | (sram_d_rvalid_i && (fifo_empty || head_err));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_id_q  <= '0;
         fifo_err_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         prio_q     <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         fifo_id_q  <= fifo_id_d;
         fifo_err_q <= fifo_err_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         prio_q     <= prio_d;
         perr_q     <= perr_d;
      end
   end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Self-checking bench for sram_d_arbiter: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_sram_d_arbiter;

   localparam logic [31:0] Base = 32'h8000_0000;
   localparam logic [31:0] End  = 32'h8000_C000;
   localparam int unsigned MaxOutst = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        m0_req_i, m1_req_i, m0_gnt_o, m1_gnt_o;
   logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
   logic        m0_we_i, m1_we_i;
   logic [3:0]  m0_be_i, m1_be_i;
   logic        m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        sram_d_req_o, sram_d_gnt_i, sram_d_we_o, sram_d_rvalid_i;
   logic [31:0] sram_d_addr_o, sram_d_wdata_o, sram_d_rdata_i;
   logic [3:0]  sram_d_be_o;
   logic        protocol_err_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   sram_d_arbiter #(
      .SRAM_BASE_ADDR(Base),
      .SRAM_END_ADDR (End),
      .MAX_OUTST     (MaxOutst)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .m0_req_i       (m0_req_i),
      .m0_gnt_o       (m0_gnt_o),
      .m0_addr_i      (m0_addr_i),
      .m0_we_i        (m0_we_i),
      .m0_be_i        (m0_be_i),
      .m0_wdata_i     (m0_wdata_i),
      .m0_rvalid_o    (m0_rvalid_o),
      .m0_rdata_o     (m0_rdata_o),
      .m0_err_o       (m0_err_o),
      .m1_req_i       (m1_req_i),
      .m1_gnt_o       (m1_gnt_o),
      .m1_addr_i      (m1_addr_i),
      .m1_we_i        (m1_we_i),
      .m1_be_i        (m1_be_i),
      .m1_wdata_i     (m1_wdata_i),
      .m1_rvalid_o    (m1_rvalid_o),
      .m1_rdata_o     (m1_rdata_o),
      .m1_err_o       (m1_err_o),
      .sram_d_req_o   (sram_d_req_o),
      .sram_d_gnt_i   (sram_d_gnt_i),
      .sram_d_addr_o  (sram_d_addr_o),
      .sram_d_we_o    (sram_d_we_o),
      .sram_d_be_o    (sram_d_be_o),
      .sram_d_wdata_o (sram_d_wdata_o),
      .sram_d_rvalid_i(sram_d_rvalid_i),
      .sram_d_rdata_i (sram_d_rdata_i),
      .protocol_err_o (protocol_err_o)
   );

   logic [140:0] all_out;
   assign all_out = {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o,
                     m0_rdata_o, m1_rdata_o, sram_d_req_o, sram_d_addr_o, sram_d_we_o,
                     sram_d_be_o, sram_d_wdata_o, protocol_err_o};

   task automatic drive_idle();
      m0_req_i = 0; m0_addr_i = '0; m0_we_i = 0; m0_be_i = '0; m0_wdata_i = '0;
      m1_req_i = 0; m1_addr_i = '0; m1_we_i = 0; m1_be_i = '0; m1_wdata_i = '0;
      sram_d_gnt_i = 0; sram_d_rvalid_i = 0; sram_d_rdata_i = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      drive_idle();
      rst_ni = 0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 4))
         0, 1: a = Base + 32'($urandom_range(0, 32'h0000_BFFF));
         2: a = Base - 32'd1 - 32'($urandom_range(0, 15));
         3: begin
            case ($urandom_range(0, 3))
               0: a = Base;
               1: a = End - 32'd1;
               2: a = End;
               default: a = Base - 32'd1;
            endcase
         end
         default: a = $urandom;
      endcase
      return a;
   endfunction

   task automatic test_reset();
      drive_idle();
      rst_ni = 0;
      @(negedge clk_i);
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      next_cycle();
      rst_ni = 1;
   endtask

   task automatic test_single_read();
      m0_req_i = 1; m0_addr_i = 32'h8000_0010; sram_d_gnt_i = 1;
      @(negedge clk_i);
      checks++;
      if ({m0_gnt_o, m1_gnt_o, sram_d_req_o, sram_d_addr_o} !== {3'b101, 32'h8000_0010}) begin
         errors++;
         $display("FAIL single_grant: got %b%b%b %h expected 101 80000010",
                  m0_gnt_o, m1_gnt_o, sram_d_req_o, sram_d_addr_o);
      end
      next_cycle();
      drive_idle();
      sram_d_rvalid_i = 1; sram_d_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      checks++;
      if ({m0_rvalid_o, m0_err_o, m1_rvalid_o, m0_rdata_o} !== {3'b100, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL single_resp: got rv0=%b err0=%b rv1=%b rdata=%h expected 1 0 0 deadbeef",
                  m0_rvalid_o, m0_err_o, m1_rvalid_o, m0_rdata_o);
      end
      next_cycle();
      drive_idle();
   endtask

   task automatic test_contention();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_idle();
         if (i < 4) begin
            m0_req_i = 1; m0_addr_i = Base + 32'h100;
            m1_req_i = 1; m1_addr_i = Base + 32'h200;
            sram_d_gnt_i = 1;
         end
         sram_d_rvalid_i = (i > 0);
         sram_d_rdata_i  = 32'h1000 + 32'(i);
         @(negedge clk_i);
         if (i < 4) begin
            checks++;
            if ({m0_gnt_o, m1_gnt_o, sram_d_addr_o} !==
                {(i % 2 == 0), (i % 2 == 1), Base + ((i % 2 == 0) ? 32'h100 : 32'h200)}) begin
               errors++;
               $display("FAIL contention_gnt[%0d]: got %b%b %h expected m%0d", i,
                        m0_gnt_o, m1_gnt_o, sram_d_addr_o, i % 2);
            end
         end
         if (i > 0) begin
            checks++;
            if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o | m1_rdata_o} !==
                {((i - 1) % 2 == 0), ((i - 1) % 2 == 1), 32'h1000 + 32'(i)}) begin
               errors++;
               $display("FAIL contention_rsp[%0d]: got rv=%b%b data=%h expected m%0d %h", i,
                        m0_rvalid_o, m1_rvalid_o, m0_rdata_o | m1_rdata_o, (i - 1) % 2,
                        32'h1000 + 32'(i));
            end
         end
         next_cycle();
      end
      drive_idle();
   endtask

   task automatic test_out_of_range();
      m1_req_i = 1; m1_addr_i = End; m1_we_i = 1; m1_be_i = 4'hF; m1_wdata_i = 32'h1234_5678;
      sram_d_gnt_i = 1;
      @(negedge clk_i);
      checks++;
      if ({sram_d_req_o, m0_gnt_o, m1_gnt_o, sram_d_addr_o} !== {3'b001, 32'h0}) begin
         errors++;
         $display("FAIL oor_grant: got req=%b gnt=%b%b addr=%h expected 0 01 0",
                  sram_d_req_o, m0_gnt_o, m1_gnt_o, sram_d_addr_o);
      end
      next_cycle();
      drive_idle();
      @(negedge clk_i);
      checks++;
      if ({m1_rvalid_o, m1_err_o, m0_rvalid_o, m1_rdata_o} !== {3'b110, 32'h0}) begin
         errors++;
         $display("FAIL oor_resp: got rv1=%b err1=%b rv0=%b rdata=%h expected 1 1 0 0",
                  m1_rvalid_o, m1_err_o, m0_rvalid_o, m1_rdata_o);
      end
      next_cycle();
   endtask

   task automatic test_mixed();
      m0_req_i = 1; m0_addr_i = Base + 32'h40; sram_d_gnt_i = 1;
      @(negedge clk_i);
      checks++;
      if (m0_gnt_o !== 1'b1) begin
         errors++;
         $display("FAIL mixed_gnt0: got %b expected 1", m0_gnt_o);
      end
      next_cycle();
      drive_idle();
      m1_req_i = 1; m1_addr_i = 32'h0000_1000;
      sram_d_rvalid_i = 1; sram_d_rdata_i = 32'h0000_0055;
      @(negedge clk_i);
      checks++;
      if ({m0_rvalid_o, m1_rvalid_o, m1_gnt_o, m0_rdata_o} !== {3'b101, 32'h55}) begin
         errors++;
         $display("FAIL mixed_first: got rv=%b%b gnt1=%b rdata0=%h expected 10 1 55",
                  m0_rvalid_o, m1_rvalid_o, m1_gnt_o, m0_rdata_o);
      end
      next_cycle();
      drive_idle();
      @(negedge clk_i);
      checks++;
      if ({m0_rvalid_o, m1_rvalid_o, m1_err_o} !== 3'b011) begin
         errors++;
         $display("FAIL mixed_second: got rv=%b%b err1=%b expected 01 1",
                  m0_rvalid_o, m1_rvalid_o, m1_err_o);
      end
      next_cycle();
   endtask

   task automatic test_full_fifo();
      for (int i = 0; i < 8; i++) begin
         drive_idle();
         if (i < 5) begin
            m0_req_i = 1; m0_addr_i = Base + 32'h10;
            m1_req_i = 1; m1_addr_i = Base + 32'h20;
            sram_d_gnt_i = 1;
         end
         sram_d_rvalid_i = (i >= 4 && i <= 6);
         sram_d_rdata_i  = 32'hA0 + 32'(i);
         @(negedge clk_i);
         if (i < 5) begin
            checks++;
            if ((m0_gnt_o + m1_gnt_o) !== ((i < 2 || i == 4) ? 1 : 0)) begin
               errors++;
               $display("FAIL full_gnt[%0d]: got %b%b expected %0d grant(s)", i,
                        m0_gnt_o, m1_gnt_o, (i < 2 || i == 4) ? 1 : 0);
            end
         end
         checks++;
         if ((m0_rvalid_o + m1_rvalid_o) !== ((i >= 4 && i <= 6) ? 1 : 0)) begin
            errors++;
            $display("FAIL full_rsp[%0d]: got rv=%b%b expected %0d response(s)", i,
                     m0_rvalid_o, m1_rvalid_o, (i >= 4 && i <= 6) ? 1 : 0);
         end
         next_cycle();
      end
      drive_idle();
   endtask

   task automatic test_reset_protocol();
      for (int i = 0; i < 2; i++) begin
         m0_req_i = 1; m0_addr_i = Base + 32'(i * 4); sram_d_gnt_i = 1;
         next_cycle();
      end
      drive_idle();
      rst_ni = 0;
      @(negedge clk_i);
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got %h expected 0", all_out);
      end
      next_cycle();
      rst_ni = 1;
      @(negedge clk_i);
      checks++;
      if (protocol_err_o !== 1'b0) begin
         errors++;
         $display("FAIL perr_after_reset: got %b expected 0", protocol_err_o);
      end
      next_cycle();
      sram_d_rvalid_i = 1; sram_d_rdata_i = 32'hCAFE_F00D;
      @(negedge clk_i);
      checks++;
      if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
         errors++;
         $display("FAIL stray_rvalid: got %b%b expected 00", m0_rvalid_o, m1_rvalid_o);
      end
      next_cycle();
      drive_idle();
      @(negedge clk_i);
      checks++;
      if (protocol_err_o !== 1'b1) begin
         errors++;
         $display("FAIL perr_sticky: got %b expected 1", protocol_err_o);
      end
      next_cycle();
   endtask

   typedef struct packed {
      logic id;
      logic err;
   } ent_t;

   task automatic test_random();
      ent_t        q[$];
      ent_t        head;
      logic        prio = 0, perr = 0, rsp_pend = 0;
      logic        pop, ok, s1, sreq, inr, e_fwd, e_gnt;
      logic [31:0] saddr, e_data;
      logic [68:0] e_fields;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         m0_req_i = 1'($urandom_range(0, 1)); m0_addr_i = rand_addr();
         m0_we_i = 1'($urandom); m0_be_i = 4'($urandom); m0_wdata_i = $urandom;
         m1_req_i = 1'($urandom_range(0, 1)); m1_addr_i = rand_addr();
         m1_we_i = 1'($urandom); m1_be_i = 4'($urandom); m1_wdata_i = $urandom;
         sram_d_gnt_i = ($urandom_range(0, 3) != 0);
         sram_d_rvalid_i = rsp_pend;
         sram_d_rdata_i = $urandom;
         @(negedge clk_i);
         head  = (q.size() != 0) ? q[0] : '0;
         pop   = (q.size() != 0) && (head.err || sram_d_rvalid_i);
         ok    = (q.size() < MaxOutst) || pop;
         s1    = m1_req_i && (!m0_req_i || prio);
         sreq  = m0_req_i || m1_req_i;
         saddr = s1 ? m1_addr_i : m0_addr_i;
         inr   = (saddr >= Base) && (saddr < End);
         e_fwd = sreq && inr && ok;
         e_gnt = inr ? (e_fwd && sram_d_gnt_i) : (sreq && ok);
         e_fields = !e_fwd ? '0 : s1 ? {m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i}
                                     : {m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i};
         e_data = head.err ? 32'h0 : sram_d_rdata_i;
         perr = perr | (sram_d_rvalid_i && ((q.size() == 0) || head.err));
         checks++;
         if ({m0_gnt_o, m1_gnt_o, sram_d_req_o} !== {e_gnt && !s1, e_gnt && s1, e_fwd}) begin
            errors++;
            $display("FAIL rand_gnt[%0d]: got %b%b%b expected %b%b%b", c, m0_gnt_o, m1_gnt_o,
                     sram_d_req_o, e_gnt && !s1, e_gnt && s1, e_fwd);
         end
         checks++;
         if ({sram_d_addr_o, sram_d_we_o, sram_d_be_o, sram_d_wdata_o} !== e_fields) begin
            errors++;
            $display("FAIL rand_fields[%0d]: got %h expected %h", c,
                     {sram_d_addr_o, sram_d_we_o, sram_d_be_o, sram_d_wdata_o}, e_fields);
         end
         checks++;
         if ({m0_rvalid_o, m0_err_o, m0_rdata_o, m1_rvalid_o, m1_err_o, m1_rdata_o} !==
             {pop && !head.id, pop && !head.id && head.err, (pop && !head.id) ? e_data : 32'h0,
              pop && head.id, pop && head.id && head.err, (pop && head.id) ? e_data : 32'h0})
         begin
            errors++;
            $display("FAIL rand_rsp[%0d]: got rv=%b%b err=%b%b data=%h/%h expected m%0d pop=%b",
                     c, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, m0_rdata_o, m1_rdata_o,
                     head.id, pop);
         end
         checks++;
         if (protocol_err_o !== perr) begin
            errors++;
            $display("FAIL rand_perr[%0d]: got %b expected %b", c, protocol_err_o, perr);
         end
         if (pop) void'(q.pop_front());
         if (e_gnt) begin
            q.push_back('{id: s1, err: !inr});
            prio = !s1;
         end
         rsp_pend = e_fwd && sram_d_gnt_i;
         next_cycle();
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_single_read();
      test_contention();
      test_out_of_range();
      test_mixed();
      test_full_fifo();
      test_reset_protocol();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
